// File: rtl/alu_iterative_if.sv
// Operand/result bundle between the controller and the iterative ALU.
// The controller drives the request side; the ALU returns the result and status.
`timescale 1ns/1ps
interface alu_iterative_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic             busy;
  logic             done;

  modport master (
    output start, ALUControl, SrcA, SrcB,
    input  ALUResult, Zero, busy, done
  );

  modport slave (
    input  start, ALUControl, SrcA, SrcB,
    output ALUResult, Zero, busy, done
  );
endinterface

// File: rtl/alu_iterative.sv
// Multi-cycle execute-stage ALU: logic/arith/compare finish in one cycle,
// shifts move one bit per cycle through a single shift register.
//
//   state | meaning
//   IDLE  | waiting for start; single-cycle ops complete from here
//   SHIFT | iterative shift in progress, busy=1
`timescale 1ns/1ps
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  alu_iterative_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [SHW-1:0]   cnt_q,   cnt_d;
  logic             left_q,  left_d;
  logic             fill_q,  fill_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q,  done_d;

  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             slt_bit;
  logic [WIDTH-1:0] op_result;
  logic [WIDTH-1:0] shifted;

  assign shamt    = bus.SrcB[SHW-1:0];
  assign is_shift = (bus.ALUControl == OP_SLL) || (bus.ALUControl == OP_SRL) ||
                    (bus.ALUControl == OP_SRA);
  assign slt_bit  = $signed(bus.SrcA) < $signed(bus.SrcB);

  // Shift codes resolve to SrcA here; that value is only used when k=0.
  always_comb begin
    op_result = '0;
    case (bus.ALUControl)
      OP_ADD:  op_result = bus.SrcA + bus.SrcB;
      OP_SUB:  op_result = bus.SrcA - bus.SrcB;
      OP_AND:  op_result = bus.SrcA & bus.SrcB;
      OP_OR:   op_result = bus.SrcA | bus.SrcB;
      OP_XOR:  op_result = bus.SrcA ^ bus.SrcB;
      OP_SLT:  op_result = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLL,
      OP_SRL,
      OP_SRA:  op_result = bus.SrcA;
      default: op_result = '0;
    endcase
  end

  assign shifted = left_q ? {shreg_q[WIDTH-2:0], 1'b0}
                          : {fill_q, shreg_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    fill_d   = fill_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (is_shift && (shamt != '0)) begin
            shreg_d = bus.SrcA;
            cnt_d   = shamt;
            left_d  = (bus.ALUControl == OP_SLL);
            fill_d  = (bus.ALUControl == OP_SRA) && bus.SrcA[WIDTH-1];
            state_d = SHIFT;
          end else begin
            result_d = op_result;
            done_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        shreg_d = shifted;
        cnt_d   = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d = shifted;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      fill_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      fill_q   <= fill_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.ALUResult = result_q;
  assign bus.Zero      = (result_q == '0);
  assign bus.busy      = (state_q == SHIFT);
  assign bus.done      = done_q;

endmodule

// File: doc/alu_iterative.md
# alu_iterative

Multi-cycle ALU execution unit that consumes the 4-bit ALUControl code from the ALU decoder and produces ALUResult and Zero. It sits in the execute stage of the multi-cycle RISC-V core.
- Logic, arithmetic and compare operations complete in one cycle.
- Shifts use a one-bit-per-cycle iterative shifter instead of a barrel shifter, trading latency for area.
- The controller starts an operation with a start pulse and waits for done.

## Interface
- WIDTH, 32: datapath width; shift amount field is SrcB[$clog2(WIDTH)-1:0].
- clk  input  1  system clock, all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request; accepted only when busy=0.
- ALUControl  input  4  operation code, sampled at accepted start.
- SrcA  input  WIDTH  operand A, sampled at accepted start.
- SrcB  input  WIDTH  operand B / shift amount, sampled at accepted start.
- ALUResult  output  WIDTH  registered result of last completed operation.
- Zero  output  1  1 when ALUResult==0.
- busy  output  1  1 while an iterative shift is in progress.
- done  output  1  one-cycle pulse when ALUResult has been updated.

## Operation
- Encodings:
  - 0000: add, A+B modulo 2^WIDTH.
  - 0001: sub, A-B modulo 2^WIDTH.
  - 0010: and.
  - 0011: or.
  - 0100: sll.
  - 0101: slt, signed compare; result {WIDTH-1 zeros, A<B}.
  - 0110: xor.
  - 0111: srl, zero fill.
  - 1000: sra, sign fill.
- Any other code: result 0, completes as a single-cycle operation.
- No overflow or carry outputs; arithmetic wraps silently.
- State machine: IDLE, SHIFT.
- IDLE, accepted start with a non-shift code or shift amount k=0:
  - ALUResult loaded (k=0 shift gives SrcA).
  - done=1 next cycle.
  - Stay in IDLE.
- IDLE, accepted start with a shift code and k>=1:
  - Load internal shift register with SrcA, count with k, latch direction/fill.
  - Go to SHIFT.
- SHIFT, each cycle:
  - Shift register moves one bit. sll inserts 0 at LSB; srl inserts 0 at MSB; sra inserts the original SrcA MSB.
  - Count decrements.
  - When count==1, the final shift is performed, ALUResult is loaded with the shifted value, done is pulsed and the state returns to IDLE.
- ALUResult and Zero hold their value through SHIFT. They change only on the cycle done rises.
- start while busy=1: ignored entirely; no queueing, operands not sampled.
- Zero is derived combinationally from the ALUResult register.

## Timing
- Reset (reset=0 at an edge):
  - State IDLE.
  - ALUResult=0, Zero=1, busy=0, done=0.
  - Shift register and count cleared.
  - Overrides any in-flight shift; no done is produced for the aborted operation.
- Start sampled in cycle N (start=1, busy=0).
- Single-cycle ops and k=0: done=1 and new ALUResult in cycle N+1. busy never asserts.
- Shift with k>=1:
  - busy=1 in cycles N+1..N+k.
  - done=1, busy=0, new ALUResult in cycle N+k+1.
  - Maximum latency is WIDTH cycles (k=WIDTH-1).
- done is high exactly one cycle per accepted start and is never high while busy=1.
- Back-to-back:
  - A start in the done cycle (busy=0) is accepted.
  - The done pulse of the previous operation is unaffected.
  - The new operation's done follows the rules above, so single-cycle ops can issue every cycle.
- reset=0 coincident with start: reset wins, start dropped.

## Test plan
- Reset: hold reset=0 for 2 cycles with start=1 -> ALUResult=0x00000000, Zero=1, busy=0, done=0, and no done after release.
- Arithmetic:
  - add 0x7FFFFFFF+0x00000001 -> 0x80000000, done at N+1.
  - sub 5-5 -> 0, Zero=1.
  - sub 0-1 -> 0xFFFFFFFF.
- Compare/logic:
  - slt A=0xFFFFFFFF, B=1 -> 1.
  - slt A=1, B=0xFFFFFFFF -> 0.
  - and/or/xor of 0xF0F0F0F0 and 0xFF00FF00 -> 0xF000F000 / 0xFFF0FFF0 / 0x0FF00FF0.
  - code 1111 -> 0, done at N+1.
- Shifts, A=0x80000000, B=4:
  - sra -> 0xF8000000, busy N+1..N+4, done at N+5.
  - srl -> 0x08000000.
  - sll A=1, B=31 -> 0x80000000, done at N+32.
  - sll B=0x20, masked to 0 -> A, done at N+1.
- Handshake:
  - start pulses during busy -> ignored; ALUResult holds the old value until done.
  - Start issued in the done cycle -> accepted, correct second result.
- Reset mid-shift: sra by 10, reset=0 at N+3 -> ALUResult=0, busy=0, no done pulse afterwards.
